periph_link_arbiter: RTL and testbench

- Shares one peripheral send/ack/data link between NUM_REQ CPU-side requesters, each running the four-phase send/ack handshake.
- Sits between the CPU FSM instances and the single peripheral.
- Round-robin grant; latches the winner's data for the whole transfer.
- Optional ack timeout toward the peripheral; wrapping transfer counter.

---
 rtl/periph_link_arbiter.sv | 171 +++++++++++++++++
 tb/tb_periph_link_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_link_arbiter.sv
// Round-robin arbiter sharing one four-phase send/ack peripheral link
// between NUM_REQ requesters. The winner's payload is latched for the whole
// transfer. An optional ack timeout completes a stuck transfer with an error
// flag. Every output comes straight from a register.
module periph_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_send,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        ack_err,
  output logic                        peri_send,
  output logic [DATA_W-1:0]           peri_data,
  input  logic                        peri_ack,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [7:0]                  xfer_count,
  output logic                        timeout_pulse
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_q, rr_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [15:0]             wait_q, wait_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    send_q, send_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [7:0]              count_q, count_d;
  logic                    tpulse_q, tpulse_d;

  logic [DATA_W-1:0]       req_words [NUM_REQ];
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic                    timed_out;

  // Split the flat payload bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_words[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first active send line at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_send[ID_W'((int'(rr_q) + i) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (wait_q == 16'(TIMEOUT - 1));

  // Next-state and registered-output logic for the IDLE/FWD/ACK handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    wait_d   = wait_q;
    data_d   = data_q;
    send_d   = send_q;
    ack_d    = ack_q;
    err_d    = err_q;
    busy_d   = busy_q;
    count_d  = count_q;
    tpulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A stale ack from the previous transfer blocks a new grant.
        if (win_found && !peri_ack) begin
          grant_d = win_idx;
          data_d  = req_words[win_idx];
          send_d  = 1'b1;
          busy_d  = 1'b1;
          wait_d  = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        // A real ack beats a timeout landing in the same cycle.
        if (peri_ack) begin
          send_d         = 1'b0;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b0;
          state_d        = S_ACK;
        end else if (timed_out) begin
          send_d         = 1'b0;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          tpulse_d       = 1'b1;
          state_d        = S_ACK;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_ACK: begin
        // Both sides must have released the handshake in the same cycle.
        if (!req_send[grant_q] && !peri_ack) begin
          ack_d   = '0;
          err_d   = 1'b0;
          count_d = count_q + 8'd1;
          rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      send_q   <= send_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign req_ack       = ack_q;
  assign ack_err       = err_q;
  assign peri_send     = send_q;
  assign peri_data     = data_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign xfer_count    = count_q;
  assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_periph_link_arbiter.sv
// Self-checking bench for periph_link_arbiter: a cycle vector table, hand
// sequences for round-robin order, timeout and ack/timeout collision, then
// randomized requester/peripheral agents checked against protocol rules.
module tb_periph_link_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_send;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           ack_err;
  logic           peri_send;
  logic [W-1:0]   peri_data;
  logic           peri_ack;
  logic [1:0]     grant_id;
  logic           busy;
  logic [7:0]     xfer_count;
  logic           timeout_pulse;

  int checks = 0;
  int errors = 0;

  periph_link_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_send      (req_send),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .ack_err       (ack_err),
    .peri_send     (peri_send),
    .peri_data     (peri_data),
    .peri_ack      (peri_ack),
    .grant_id      (grant_id),
    .busy          (busy),
    .xfer_count    (xfer_count),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_send = '0;
    req_data = '0;
    peri_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Round-robin rule: first set bit scanning upward from the pointer.
  function automatic int winner(input logic [N-1:0] s, input int p);
    for (int i = 0; i < N; i++)
      if (s[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  typedef struct {
    logic           rst;
    logic [N-1:0]   send;
    logic [N*W-1:0] data;
    logic           pack;
    logic           e_psend;
    logic [W-1:0]   e_pdata;
    logic [1:0]     e_gid;
    logic [N-1:0]   e_rack;
    logic           e_err;
    logic           e_busy;
    logic [7:0]     e_cnt;
  } vec_t;

  vec_t vecs[25];

  initial begin
    int hi;
    int exp_ptr, exp_cnt, exp_g, send_cyc, pd, pc;
    logic [W-1:0]   exp_data;
    logic [N-1:0]   d_send, p_rack;
    logic [N*W-1:0] d_data;
    logic           d_pack, p_busy;

    //          rst send     data     ack  psend pdata gid rack     err busy cnt
    vecs[0]  = '{1, 4'b0000, 16'h0000, 0,  0, 4'h0, 0, 4'b0000, 0, 0, 0}; // reset
    vecs[1]  = '{0, 4'b0010, 16'h00A0, 0,  1, 4'hA, 1, 4'b0000, 0, 1, 0}; // grant 1
    vecs[2]  = '{0, 4'b0010, 16'h00A0, 0,  1, 4'hA, 1, 4'b0000, 0, 1, 0};
    vecs[3]  = '{0, 4'b0010, 16'h00A0, 0,  1, 4'hA, 1, 4'b0000, 0, 1, 0};
    vecs[4]  = '{0, 4'b0010, 16'h00A0, 1,  0, 4'hA, 1, 4'b0010, 0, 1, 0}; // ack
    vecs[5]  = '{0, 4'b0010, 16'h00A0, 1,  0, 4'hA, 1, 4'b0010, 0, 1, 0};
    vecs[6]  = '{0, 4'b0000, 16'h00A0, 1,  0, 4'hA, 1, 4'b0010, 0, 1, 0}; // ack still high
    vecs[7]  = '{0, 4'b0000, 16'h00A0, 0,  0, 4'hA, 1, 4'b0000, 0, 0, 1}; // done, ptr=2
    vecs[8]  = '{0, 4'b0000, 16'h00A0, 0,  0, 4'hA, 1, 4'b0000, 0, 0, 1};
    vecs[9]  = '{0, 4'b0001, 16'h00A3, 0,  1, 4'h3, 0, 4'b0000, 0, 1, 1}; // wrap to 0
    vecs[10] = '{0, 4'b0001, 16'h00AF, 0,  1, 4'h3, 0, 4'b0000, 0, 1, 1}; // data held
    vecs[11] = '{0, 4'b0001, 16'h00AF, 1,  0, 4'h3, 0, 4'b0001, 0, 1, 1};
    vecs[12] = '{0, 4'b0000, 16'h00AF, 0,  0, 4'h3, 0, 4'b0000, 0, 0, 2}; // ptr=1
    vecs[13] = '{0, 4'b0100, 16'h05AF, 1,  0, 4'h3, 0, 4'b0000, 0, 0, 2}; // stale ack
    vecs[14] = '{0, 4'b0100, 16'h05AF, 0,  1, 4'h5, 2, 4'b0000, 0, 1, 2};
    vecs[15] = '{0, 4'b0100, 16'h05AF, 1,  0, 4'h5, 2, 4'b0100, 0, 1, 2};
    vecs[16] = '{0, 4'b0000, 16'h05AF, 0,  0, 4'h5, 2, 4'b0000, 0, 0, 3}; // ptr=3
    vecs[17] = '{0, 4'b1001, 16'h75AF, 0,  1, 4'h7, 3, 4'b0000, 0, 1, 3}; // grant 3
    vecs[18] = '{1, 4'b1001, 16'h75AF, 0,  0, 4'h0, 0, 4'b0000, 0, 0, 0}; // rst mid-FWD
    vecs[19] = '{0, 4'b1001, 16'h75AF, 0,  1, 4'hF, 0, 4'b0000, 0, 1, 0}; // from ptr 0
    vecs[20] = '{0, 4'b1001, 16'h75AF, 1,  0, 4'hF, 0, 4'b0001, 0, 1, 0};
    vecs[21] = '{0, 4'b1000, 16'h75AF, 0,  0, 4'hF, 0, 4'b0000, 0, 0, 1}; // ptr=1
    vecs[22] = '{0, 4'b1000, 16'h75AF, 0,  1, 4'h7, 3, 4'b0000, 0, 1, 1};
    vecs[23] = '{0, 4'b1000, 16'h75AF, 1,  0, 4'h7, 3, 4'b1000, 0, 1, 1};
    vecs[24] = '{0, 4'b0000, 16'h75AF, 0,  0, 4'h7, 3, 4'b0000, 0, 0, 2};

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      req_send = vecs[i].send;
      req_data = vecs[i].data;
      peri_ack = vecs[i].pack;
      step();
      check($sformatf("vec%0d.peri_send", i), 32'(peri_send), 32'(vecs[i].e_psend));
      check($sformatf("vec%0d.peri_data", i), 32'(peri_data), 32'(vecs[i].e_pdata));
      check($sformatf("vec%0d.grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("vec%0d.req_ack", i), 32'(req_ack), 32'(vecs[i].e_rack));
      check($sformatf("vec%0d.ack_err", i), 32'(ack_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d.xfer_count", i), 32'(xfer_count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.timeout_pulse", i), 32'(timeout_pulse), 32'd0);
    end

    // ---------------- round robin, all four requesting ----------------
    do_reset();
    req_send = 4'b1111;
    req_data = 16'h4321;
    for (int t = 0; t < 5; t++) begin
      step();
      for (int k = 0; k < 20 && !peri_send; k++) step();
      check($sformatf("rr%0d.granted", t), 32'(peri_send), 32'd1);
      check($sformatf("rr%0d.grant_id", t), 32'(grant_id), 32'(t % N));
      check($sformatf("rr%0d.peri_data", t), 32'(peri_data), 32'((t % N) + 1));
      peri_ack = 1'b1;
      step();
      check($sformatf("rr%0d.req_ack", t), 32'(req_ack), 32'(1 << (t % N)));
      check($sformatf("rr%0d.onehot", t), 32'($onehot0(req_ack)), 32'd1);
      req_send[t % N] = 1'b0;
      peri_ack        = 1'b0;
      step();
      check($sformatf("rr%0d.busy", t), 32'(busy), 32'd0);
      check($sformatf("rr%0d.xfer_count", t), 32'(xfer_count), 32'(t + 1));
      req_send[t % N] = 1'b1;
    end

    // ---------------- timeout, then next requester served ----------------
    do_reset();
    req_send = 4'b0101;
    req_data = 16'h0906;
    step();
    check("to.grant_id", 32'(grant_id), 32'd0);
    hi = 0;
    for (int k = 0; k < 20 && peri_send; k++) begin
      hi++;
      step();
    end
    check("to.send_cycles", 32'(hi), 32'(TO));
    check("to.req_ack", 32'(req_ack), 32'b0001);
    check("to.ack_err", 32'(ack_err), 32'd1);
    check("to.pulse", 32'(timeout_pulse), 32'd1);
    step();
    check("to.pulse_once", 32'(timeout_pulse), 32'd0);
    check("to.ack_hold", 32'(req_ack), 32'b0001);
    req_send = 4'b0100;
    step();
    check("to.count", 32'(xfer_count), 32'd1);
    check("to.err_clear", 32'(ack_err), 32'd0);
    step();
    check("to.next_grant", 32'(grant_id), 32'd2);
    check("to.next_data", 32'(peri_data), 32'h9);
    peri_ack = 1'b1;
    step();
    check("to.next_ack", 32'(req_ack), 32'b0100);
    check("to.next_err", 32'(ack_err), 32'd0);
    req_send = '0;
    peri_ack = 1'b0;
    step();
    check("to.next_count", 32'(xfer_count), 32'd2);

    // ---------------- ack and timeout in the same cycle ----------------
    req_send = 4'b0001;
    step();
    check("col.granted", 32'(peri_send), 32'd1);
    for (int k = 0; k < TO - 1; k++) step();
    check("col.still_send", 32'(peri_send), 32'd1);
    peri_ack = 1'b1;
    step();
    check("col.req_ack", 32'(req_ack), 32'b0001);
    check("col.ack_err", 32'(ack_err), 32'd0);
    check("col.no_pulse", 32'(timeout_pulse), 32'd0);
    req_send = '0;
    peri_ack = 1'b0;
    step();
    check("col.count", 32'(xfer_count), 32'd3);

    // ---------------- randomized agents against rule model ----------------
    do_reset();
    exp_ptr = 0;
    exp_cnt = 0;
    exp_g   = 0;
    exp_data = '0;
    send_cyc = 0;
    pd = 0;
    pc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      d_send = req_send;
      d_data = req_data;
      d_pack = peri_ack;
      p_busy = busy;
      p_rack = req_ack;
      step();
      check("rnd.onehot", 32'($onehot0(req_ack)), 32'd1);
      if (!p_busy) begin
        if (d_send != 0 && !d_pack) begin
          exp_g    = winner(d_send, exp_ptr);
          exp_data = d_data[exp_g*W +: W];
          send_cyc = 1;
          check("rnd.grant_send", 32'(peri_send), 32'd1);
          check("rnd.grant_id", 32'(grant_id), 32'(exp_g));
          check("rnd.grant_data", 32'(peri_data), 32'(exp_data));
          check("rnd.grant_busy", 32'(busy), 32'd1);
        end else begin
          check("rnd.idle_busy", 32'(busy), 32'd0);
          check("rnd.idle_send", 32'(peri_send), 32'd0);
        end
      end else begin
        check("rnd.hold_id", 32'(grant_id), 32'(exp_g));
        check("rnd.hold_data", 32'(peri_data), 32'(exp_data));
        if (peri_send) send_cyc++;
        if (p_rack == 0 && req_ack != 0) begin
          check("rnd.ack_target", 32'(req_ack), 32'(1 << exp_g));
          check("rnd.ack_err", 32'(ack_err), 32'(!d_pack));
          check("rnd.pulse", 32'(timeout_pulse), 32'(!d_pack));
          if (!d_pack) check("rnd.to_len", 32'(send_cyc), 32'(TO));
        end else begin
          check("rnd.no_pulse", 32'(timeout_pulse), 32'd0);
        end
        if (!busy) begin
          exp_cnt = (exp_cnt + 1) % 256;
          exp_ptr = (exp_g + 1) % N;
          check("rnd.count", 32'(xfer_count), 32'(exp_cnt));
        end
      end

      req_data = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_send[i] && !req_ack[i]) begin
          if ($urandom_range(2) == 0) req_send[i] = 1'b1;
        end else if (req_send[i] && req_ack[i]) begin
          if ($urandom_range(1) == 0) req_send[i] = 1'b0;
        end
      end
      if (!peri_ack) begin
        if (peri_send) begin
          if (pc >= pd) peri_ack = 1'b1;
          else pc++;
        end else begin
          pc = 0;
          pd = int'($urandom_range(9));
        end
      end else if (!peri_send && $urandom_range(1) == 0) begin
        peri_ack = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
